// File: rtl/mm_score_engine.sv
// Mastermind scorer: latches a code/guess pair, then scans exact matches (RED)
// and colour-only matches (WHITE) one peg per cycle before publishing the score.
module mm_score_engine #(
    parameter int unsigned PEGS    = 4,
    parameter int unsigned COLOR_W = 3,
    localparam int unsigned CNT_W  = $clog2(PEGS + 1),
    localparam int unsigned VEC_W  = PEGS * COLOR_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [VEC_W-1:0] code,
    input  logic [VEC_W-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red,
    output logic [CNT_W-1:0] white,
    output logic             win
);

    typedef enum logic [1:0] {IDLE, RED, WHITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   code_q, code_d;
    logic [VEC_W-1:0]   guess_q, guess_d;
    logic [PEGS-1:0]    code_used_q, code_used_d;
    logic [PEGS-1:0]    guess_used_q, guess_used_d;
    logic [CNT_W-1:0]   red_cnt_q, red_cnt_d;
    logic [CNT_W-1:0]   white_cnt_q, white_cnt_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               busy_d, done_d, win_d;
    logic [CNT_W-1:0]   red_d, white_d;

    logic [PEGS-1:0]    idx_oh;
    logic [COLOR_W-1:0] code_i, guess_i;
    logic               code_used_i;
    logic [PEGS-1:0]    match_oh;
    logic               found;

    // Next-state, scan datapath and registered-output values
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        guess_d      = guess_q;
        code_used_d  = code_used_q;
        guess_used_d = guess_used_q;
        red_cnt_d    = red_cnt_q;
        white_cnt_d  = white_cnt_q;
        idx_d        = idx_q;
        red_d        = red;
        white_d      = white;
        win_d        = win;
        idx_oh       = '0;
        code_i       = '0;
        guess_i      = '0;
        code_used_i  = 1'b0;
        match_oh     = '0;
        found        = 1'b0;

        for (int k = 0; k < PEGS; k++) begin
            if (idx_q == CNT_W'(k)) begin
                idx_oh[k]   = 1'b1;
                code_i      = code_q[k*COLOR_W +: COLOR_W];
                guess_i     = guess_q[k*COLOR_W +: COLOR_W];
                code_used_i = code_used_q[k];
            end
        end

        // Lowest unused guess peg carrying the current code colour
        for (int j = 0; j < PEGS; j++) begin
            if (!found && !guess_used_q[j] && (guess_q[j*COLOR_W +: COLOR_W] == code_i)) begin
                match_oh[j] = 1'b1;
                found       = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    code_d       = code;
                    guess_d      = guess;
                    code_used_d  = '0;
                    guess_used_d = '0;
                    red_cnt_d    = '0;
                    white_cnt_d  = '0;
                    idx_d        = '0;
                    state_d      = RED;
                end
            end
            RED: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (code_i == guess_i) begin
                        red_cnt_d    = red_cnt_q + CNT_W'(1);
                        code_used_d  = code_used_q | idx_oh;
                        guess_used_d = guess_used_q | idx_oh;
                    end
                    if (idx_q == CNT_W'(PEGS - 1)) begin
                        idx_d   = '0;
                        state_d = WHITE;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            WHITE: begin
                // The extra pass at idx == PEGS publishes straight from the count registers
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == CNT_W'(PEGS)) begin
                    red_d   = red_cnt_q;
                    white_d = white_cnt_q;
                    win_d   = (red_cnt_q == CNT_W'(PEGS));
                    state_d = DONE;
                end else begin
                    if (!code_used_i && found) begin
                        guess_used_d = guess_used_q | match_oh;
                        white_cnt_d  = white_cnt_q + CNT_W'(1);
                    end
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, scan registers and outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            code_q       <= '0;
            guess_q      <= '0;
            code_used_q  <= '0;
            guess_used_q <= '0;
            red_cnt_q    <= '0;
            white_cnt_q  <= '0;
            idx_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            red          <= '0;
            white        <= '0;
            win          <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            guess_q      <= guess_d;
            code_used_q  <= code_used_d;
            guess_used_q <= guess_used_d;
            red_cnt_q    <= red_cnt_d;
            white_cnt_q  <= white_cnt_d;
            idx_q        <= idx_d;
            busy         <= busy_d;
            done         <= done_d;
            red          <= red_d;
            white        <= white_d;
            win          <= win_d;
        end
    end

endmodule

// File: tb/tb_mm_score_engine.sv
// Directed bench for mm_score_engine (PEGS=4, COLOR_W=3) with hand-computed scores.
module tb_mm_score_engine;

    localparam int unsigned PEGS    = 4;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned VEC_W   = PEGS * COLOR_W;

    logic             clock;
    logic             resetn;
    logic             start;
    logic             abort;
    logic [VEC_W-1:0] code;
    logic [VEC_W-1:0] guess;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] red;
    logic [CNT_W-1:0] white;
    logic             win;

    int checks;
    int errors;
    int lat;
    int pulses;

    mm_score_engine #(.PEGS(PEGS), .COLOR_W(COLOR_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .abort  (abort),
        .code   (code),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .red    (red),
        .white  (white),
        .win    (win)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [VEC_W-1:0] pk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a start in an IDLE cycle; returns just after the accepting edge
    task automatic accept(input logic [VEC_W-1:0] c, input logic [VEC_W-1:0] g);
        code  = c;
        guess = g;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int n, input int r, input int w,
                                input int wn, input logic hold_start);
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        chk({tag, "_red"}, 32'(red), 32'(r));
        chk({tag, "_white"}, 32'(white), 32'(w));
        chk({tag, "_win"}, 32'(win), 32'(wn));
        start = hold_start;
        step();
        start = 1'b0;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        code   = '0;
        guess  = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_red", 32'(red), 32'd0);
        chk("rst_white", 32'(white), 32'd0);
        chk("rst_win", 32'(win), 32'd0);

        // First edge after reset release accepts start; start held during DONE is ignored
        @(posedge clock);
        #1;
        resetn = 1'b1;
        accept(pk(1, 2, 3, 4), pk(1, 2, 3, 4));
        chk("exact_busy", 32'(busy), 32'd1);
        wait_done(0, lat);
        check_result("exact", lat, 4, 0, 1, 1'b1);

        accept(pk(1, 2, 3, 4), pk(4, 3, 2, 1));
        wait_done(0, lat);
        check_result("reverse", lat, 0, 4, 0, 1'b0);

        // Duplicates, inputs changed after accept, start pulse in cycle 3 ignored
        accept(pk(1, 1, 2, 2), pk(1, 2, 1, 1));
        code  = pk(3, 3, 3, 3);
        guess = pk(3, 3, 3, 3);
        step();
        step();
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_red_held", 32'(red), 32'd0);
        chk("mid_white_held", 32'(white), 32'd4);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(4, lat);
        check_result("dup", lat, 1, 2, 0, 1'b0);

        accept(pk(0, 0, 0, 0), pk(5, 5, 5, 5));
        wait_done(0, lat);
        check_result("none", lat, 0, 0, 0, 1'b0);

        accept(pk(1, 2, 3, 4), pk(1, 2, 3, 5));
        wait_done(0, lat);
        check_result("three", lat, 3, 0, 0, 1'b0);

        // Abort in cycle 6 (WHITE): no done, outputs keep 3/0/0
        accept(pk(1, 2, 3, 4), pk(4, 3, 2, 1));
        for (int i = 0; i < 6; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_red", 32'(red), 32'd3);
        chk("abort_white", 32'(white), 32'd0);
        chk("abort_win", 32'(win), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);

        // Back-to-back starts in consecutive IDLE cycles
        accept(pk(7, 0, 7, 0), pk(0, 7, 0, 7));
        wait_done(0, lat);
        check_result("b2b_a", lat, 0, 4, 0, 1'b0);
        accept(pk(7, 7, 7, 7), pk(7, 7, 7, 7));
        wait_done(0, lat);
        check_result("b2b_b", lat, 4, 0, 1, 1'b0);

        // Asynchronous reset mid-score clears outputs before any clock edge
        accept(pk(1, 2, 3, 4), pk(2, 1, 4, 3));
        step();
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_red", 32'(red), 32'd0);
        chk("areset_white", 32'(white), 32'd0);
        chk("areset_win", 32'(win), 32'd0);
        step();
        step();
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        chk("areset_no_done", 32'(pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
